// File: rtl/rxshift.sv
// rxshift: USRT receive deserializer; samples the synchronised line on bit-clock falling edges.
// Optional parity checking (o_Parity_Err, i_Parity_Odd) is built when RXSHIFT_PARITY_EN is defined.
module rxshift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Enable,
    input  logic [3:0]  i_Count,
    input  logic        i_Bclk,
    input  logic        i_Rx_Serial,
    input  logic        i_Read,
`ifdef RXSHIFT_PARITY_EN
    input  logic        i_Parity_Odd,
    output logic        o_Parity_Err,
`endif
    output logic [10:0] o_Frame,
    output logic        o_Valid,
    output logic        o_Frame_Err,
    output logic        o_Overrun,
    output logic        o_Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] bclk_p0;
    logic [SYNC_STAGES-1:0] rx_p0;
    logic                   bclk_p1;
    logic                   bclk_cur;
    logic                   rx_bit;
    logic                   fall;
    logic [3:0]             idx;
    logic [3:0]             cnt;
    logic [10:0]            shift_r;

    // Frame length index: 0 would give a start-bit-only frame, so the shortest is two bits.
    function automatic logic [3:0] clamp_count(input logic [3:0] c);
        logic [3:0] r;
        if (c == 4'd0)
            r = 4'd1;
        else if (c > 4'd10)
            r = 4'd10;
        else
            r = c;
        return r;
    endfunction

    function automatic logic [10:0] frame_mask(input logic [3:0] c);
        logic [10:0] m;
        m = '0;
        for (int i = 0; i < 11; i++)
            m[i] = (4'(i) <= c);
        return m;
    endfunction

`ifdef RXSHIFT_PARITY_EN
    // XOR of bits 1..c-1: the data bits plus the parity bit that sits just before the stop bit.
    function automatic logic parity_of(input logic [10:0] s, input logic [3:0] c);
        logic p;
        p = 1'b0;
        for (int i = 1; i < 11; i++)
            if (4'(i) < c)
                p = p ^ s[i];
        return p;
    endfunction
`endif

    // ---- synchroniser stage: line clock and data into the i_Clk domain ----
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bclk_p0 <= '1;
            rx_p0   <= '1;
            bclk_p1 <= 1'b1;
        end else begin
            bclk_p0 <= {bclk_p0[SYNC_STAGES-2:0], i_Bclk};
            rx_p0   <= {rx_p0[SYNC_STAGES-2:0], i_Rx_Serial};
            bclk_p1 <= bclk_cur;
        end
    end

    assign bclk_cur = bclk_p0[SYNC_STAGES-1];
    assign rx_bit   = rx_p0[SYNC_STAGES-1];
    assign fall     = bclk_p1 & ~bclk_cur;
    assign o_Busy   = (state == SHIFT);

    // ---- frame stage: shift register FSM and host-side holding register ----
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= IDLE;
            idx          <= 4'd0;
            cnt          <= 4'd1;
            shift_r      <= '0;
            o_Frame      <= '0;
            o_Valid      <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
`ifdef RXSHIFT_PARITY_EN
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            o_Overrun <= 1'b0;
            if (i_Read && o_Valid)
                o_Valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_Enable && fall && !rx_bit) begin
                        shift_r <= '0;
                        idx     <= 4'd1;
                        cnt     <= clamp_count(i_Count);
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!i_Enable) begin
                        state <= IDLE;
                    end else if (fall) begin
                        shift_r[idx] <= rx_bit;
                        if (idx == cnt)
                            state <= DONE;
                        else
                            idx <= idx + 4'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    // A load in the same cycle as a read wins, so o_Valid stays set.
                    if (i_Enable) begin
                        if (!o_Valid || i_Read) begin
                            o_Frame     <= shift_r & frame_mask(cnt);
                            o_Valid     <= 1'b1;
                            o_Frame_Err <= shift_r[0] | ~shift_r[cnt];
`ifdef RXSHIFT_PARITY_EN
                            o_Parity_Err <= (cnt < 4'd3) ? 1'b0
                                          : (parity_of(shift_r, cnt) != i_Parity_Odd);
`endif
                        end else begin
                            o_Overrun <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rxshift.sv
// Directed bench for rxshift: drives the line like txshift and checks outputs against a frame-level model.
module tb_rxshift;

    localparam int HALF = 6;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_Enable;
    logic [3:0]  i_Count;
    logic        i_Bclk;
    logic        i_Rx_Serial;
    logic        i_Read;
    logic [10:0] o_Frame;
    logic        o_Valid;
    logic        o_Frame_Err;
    logic        o_Overrun;
    logic        o_Busy;
`ifdef RXSHIFT_PARITY_EN
    logic        i_Parity_Odd;
    logic        o_Parity_Err;
    logic        exp_perr;
`endif

    int          n_vec;
    int          n_err;
    int          ovr_seen;
    int          exp_ovr;
    logic        chk_en;
    logic [10:0] exp_frame;
    logic        exp_valid;
    logic        exp_err;

    rxshift #(.SYNC_STAGES(2)) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Enable    (i_Enable),
        .i_Count     (i_Count),
        .i_Bclk      (i_Bclk),
        .i_Rx_Serial (i_Rx_Serial),
        .i_Read      (i_Read),
`ifdef RXSHIFT_PARITY_EN
        .i_Parity_Odd(i_Parity_Odd),
        .o_Parity_Err(o_Parity_Err),
`endif
        .o_Frame     (o_Frame),
        .o_Valid     (o_Valid),
        .o_Frame_Err (o_Frame_Err),
        .o_Overrun   (o_Overrun),
        .o_Busy      (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1);
    end

    always @(negedge i_Clk) begin
        if (o_Overrun === 1'b1)
            ovr_seen++;
    end

    // Every-cycle comparison against the frame-level model while no frame is completing.
    always @(negedge i_Clk) begin
        if (chk_en) begin
            logic bad;
            n_vec++;
            bad = (o_Valid !== exp_valid) || (o_Frame !== exp_frame) ||
                  (o_Frame_Err !== exp_err) || (o_Overrun !== 1'b0);
`ifdef RXSHIFT_PARITY_EN
            bad = bad || (o_Parity_Err !== exp_perr);
`endif
            if (bad) begin
                n_err++;
                if (n_err < 20)
                    $display("FAIL cycle_model t=%0t: got valid=%b frame=%03h err=%b ovr=%b, required valid=%b frame=%03h err=%b ovr=0",
                             $time, o_Valid, o_Frame, o_Frame_Err, o_Overrun, exp_valid, exp_frame, exp_err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %03h required %03h", name, act, req);
        end
    endtask

    function automatic int clampc(input logic [3:0] c);
        if (c == 4'd0) return 1;
        if (c > 4'd10) return 10;
        return int'(c);
    endfunction

    // Outcome of a completed frame: deliver it to the host or count an overrun.
    task automatic model_done(input logic [10:0] bits, input int cnt, input bit rd);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i <= cnt; i++)
            f[i] = bits[i];
        if (!exp_valid || rd) begin
            exp_frame = f;
            exp_valid = 1'b1;
            exp_err   = (f[0] != 1'b0) || (f[cnt] != 1'b1);
`ifdef RXSHIFT_PARITY_EN
            begin
                int ones;
                ones = 0;
                for (int i = 1; i < cnt; i++)
                    ones += int'(f[i]);
                exp_perr = (cnt < 3) ? 1'b0 : ((ones % 2) != int'(i_Parity_Odd));
            end
`endif
        end else begin
            exp_ovr++;
        end
    endtask

    // Drive nfall bits, data changing with the rising bit clock and sampled on the falling one.
    task automatic send_bits(input logic [10:0] bits, input int nfall, input bit complete, input bit rd_done);
        for (int i = 0; i < nfall; i++) begin
            i_Rx_Serial = bits[i];
            i_Bclk = 1'b1;
            tick(HALF);
            if (complete && i == nfall - 1) begin
                chk_en = 1'b0;
                i_Bclk = 1'b0;
                if (rd_done) begin
                    tick(3);
                    check("busy_in_done", {10'd0, o_Busy}, 11'd0);
                    i_Read = 1'b1;
                    tick(1);
                    i_Read = 1'b0;
                    tick(HALF - 4);
                end else begin
                    tick(HALF);
                end
            end else begin
                i_Bclk = 1'b0;
                tick(HALF);
            end
        end
    endtask

    task automatic frame(input logic [10:0] bits, input logic [3:0] count_in, input bit rd_done);
        int cnt;
        cnt = clampc(count_in);
        i_Count = count_in;
        send_bits(bits, cnt + 1, 1'b1, rd_done);
        i_Bclk = 1'b1;
        i_Rx_Serial = 1'b1;
        model_done(bits, cnt, rd_done);
        chk_en = 1'b1;
        tick(4);
    endtask

    task automatic host_read();
        i_Read = 1'b1;
        tick(1);
        i_Read = 1'b0;
        exp_valid = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [10:0] v;
        n_vec = 0; n_err = 0; ovr_seen = 0; exp_ovr = 0;
        chk_en = 1'b0;
        exp_frame = '0; exp_valid = 1'b0; exp_err = 1'b0;
        i_Rst = 1'b1; i_Enable = 1'b1; i_Count = 4'd9;
        i_Bclk = 1'b1; i_Rx_Serial = 1'b1; i_Read = 1'b0;
`ifdef RXSHIFT_PARITY_EN
        i_Parity_Odd = 1'b0;
        exp_perr = 1'b0;
`endif
        tick(3);
        check("rst_frame", o_Frame, 11'h000);
        check("rst_valid", {10'd0, o_Valid}, 11'd0);
        check("rst_ferr", {10'd0, o_Frame_Err}, 11'd0);
        check("rst_ovr", {10'd0, o_Overrun}, 11'd0);
        check("rst_busy", {10'd0, o_Busy}, 11'd0);
        i_Rst = 1'b0;
        tick(2);
        chk_en = 1'b1;

        // Alternating frame with a good stop bit
        frame(11'h2AA, 4'd9, 1'b0);
        check("alt_frame", o_Frame, 11'h2AA);
        check("alt_valid", {10'd0, o_Valid}, 11'd1);
        check("alt_ferr", {10'd0, o_Frame_Err}, 11'd0);

        // Missing stop bit, then host read
        host_read();
        frame(11'h0AA, 4'd9, 1'b0);
        check("nostop_valid", {10'd0, o_Valid}, 11'd1);
        check("nostop_ferr", {10'd0, o_Frame_Err}, 11'd1);
        host_read();
        check("read_valid", {10'd0, o_Valid}, 11'd0);
        check("read_retain", o_Frame, 11'h0AA);

        // Count clamping at both ends
        frame(11'h002, 4'd0, 1'b0);
        check("cnt0_frame", o_Frame, 11'h002);
        check("cnt0_ferr", {10'd0, o_Frame_Err}, 11'd0);
        host_read();
        frame(11'h4D2, 4'd15, 1'b0);
        check("cnt15_frame", o_Frame, 11'h4D2);
        host_read();

        // Overrun, then a read landing in the DONE cycle
        frame(11'h2AA, 4'd9, 1'b0);
        frame(11'h0AA, 4'd9, 1'b0);
        check("ovr_pulses", 11'(ovr_seen), 11'd1);
        check("ovr_retain", o_Frame, 11'h2AA);
        frame(11'h0AA, 4'd9, 1'b1);
        check("rdone_frame", o_Frame, 11'h0AA);
        check("rdone_valid", {10'd0, o_Valid}, 11'd1);
        check("rdone_ovr", 11'(ovr_seen), 11'd1);
        host_read();

        // Abort by i_Enable at idx=5, then idle line with clock running
        i_Count = 4'd9;
        send_bits(11'h2AA, 5, 1'b0, 1'b0);
        check("abort_busy_before", {10'd0, o_Busy}, 11'd1);
        i_Enable = 1'b0;
        tick(1);
        check("abort_busy_after", {10'd0, o_Busy}, 11'd0);
        v = 11'h2AA >> 5;
        send_bits(v, 5, 1'b0, 1'b0);
        i_Bclk = 1'b1; i_Rx_Serial = 1'b1;
        i_Enable = 1'b1;
        tick(4);
        send_bits(11'h7FF, 4, 1'b0, 1'b0);
        i_Bclk = 1'b1;
        tick(6);
        check("abort_valid", {10'd0, o_Valid}, 11'd0);
        check("abort_busy_idle", {10'd0, o_Busy}, 11'd0);

        // Reset in the middle of a frame
        frame(11'h2AA, 4'd9, 1'b0);
        send_bits(11'h0AA, 4, 1'b0, 1'b0);
        check("mid_busy", {10'd0, o_Busy}, 11'd1);
        i_Bclk = 1'b1; i_Rx_Serial = 1'b1;
        i_Rst = 1'b1;
        exp_frame = '0; exp_valid = 1'b0; exp_err = 1'b0;
`ifdef RXSHIFT_PARITY_EN
        exp_perr = 1'b0;
`endif
        #1;
        check("mrst_frame", o_Frame, 11'h000);
        check("mrst_valid", {10'd0, o_Valid}, 11'd0);
        check("mrst_busy", {10'd0, o_Busy}, 11'd0);
        tick(2);
        i_Rst = 1'b0;
        tick(2);
        frame(11'h0AA, 4'd9, 1'b0);
        check("post_rst_frame", o_Frame, 11'h0AA);
        check("post_rst_ferr", {10'd0, o_Frame_Err}, 11'd1);
        host_read();

`ifdef RXSHIFT_PARITY_EN
        // Even parity: data A5 with parity bit 0 is good, parity bit 1 is bad
        i_Parity_Odd = 1'b0;
        frame(11'h54A, 4'd10, 1'b0);
        check("par_good", {10'd0, o_Parity_Err}, 11'd0);
        host_read();
        frame(11'h74A, 4'd10, 1'b0);
        check("par_bad", {10'd0, o_Parity_Err}, 11'd1);
        check("par_frame", o_Frame, 11'h74A);
        host_read();
`endif

        check("ovr_total", 11'(ovr_seen), 11'(exp_ovr));
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
